// File: rtl/ddr5_cmd_responder.sv
// Device-side DDR5 command bus responder: reassembles two-cycle commands,
// tracks per-bank state and timing, reports violations and returns
// read/write completions after CL/CWL.
module ddr5_cmd_responder #(
  parameter int unsigned BG_BITS  = 3,
  parameter int unsigned BA_BITS  = 2,
  parameter int unsigned ROW_BITS = 16,
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned T_RCD    = 39,
  parameter int unsigned T_RP     = 39,
  parameter int unsigned T_CL     = 40,
  parameter int unsigned T_CWL    = 38,
  parameter int unsigned T_RFC    = 295
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            cmd_valid,
  input  logic [2:0]                                      cmd,
  input  logic [BG_BITS-1:0]                              cmd_bg,
  input  logic [BA_BITS-1:0]                              cmd_bank,
  input  logic [ROW_BITS-1:0]                             cmd_row,
  input  logic [COL_BITS-1:0]                             cmd_col,
  output logic                                            rd_valid,
  output logic [BG_BITS+BA_BITS+ROW_BITS+COL_BITS-1:0]    rd_addr,
  output logic                                            wr_done,
  output logic [BG_BITS+BA_BITS+ROW_BITS+COL_BITS-1:0]    wr_addr,
  output logic                                            err_valid,
  output logic [2:0]                                      err_code,
  output logic                                            busy,
  output logic [(32'd1 << (BG_BITS+BA_BITS))-1:0]         open_mask
);

  localparam int unsigned BANK_BITS = BG_BITS + BA_BITS;
  localparam int unsigned NUM_BANKS = 32'd1 << BANK_BITS;
  localparam int unsigned ADDR_W    = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int unsigned T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned TMR_W     = $clog2(T_MAX + 1);
  localparam int unsigned RFC_W     = $clog2(T_RFC + 1);

  localparam logic [2:0] CMD_ACT0 = 3'd0;
  localparam logic [2:0] CMD_ACT1 = 3'd1;
  localparam logic [2:0] CMD_RD0  = 3'd2;
  localparam logic [2:0] CMD_RD1  = 3'd3;
  localparam logic [2:0] CMD_WR1  = 3'd5;
  localparam logic [2:0] CMD_PRE  = 3'd6;
  localparam logic [2:0] CMD_REF  = 3'd7;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SEQ      = 3'd1;
  localparam logic [2:0] ERR_OPEN     = 3'd2;
  localparam logic [2:0] ERR_CLOSED   = 3'd3;
  localparam logic [2:0] ERR_TRCD     = 3'd4;
  localparam logic [2:0] ERR_TRP      = 3'd5;
  localparam logic [2:0] ERR_REF_OPEN = 3'd6;
  localparam logic [2:0] ERR_BUSY     = 3'd7;

  typedef enum logic {ST_IDLE, ST_HALF} state_t;

  state_t                state;
  logic [2:0]            pend_cmd;
  logic [BANK_BITS-1:0]  pend_bank;
  logic [ROW_BITS-1:0]   pend_row;
  logic [COL_BITS-1:0]   pend_col;

  logic [ROW_BITS-1:0]   row_q [NUM_BANKS];
  logic [TMR_W-1:0]      tmr_q [NUM_BANKS];
  logic [RFC_W-1:0]      rfc_cnt;

  logic [T_CL-1:0]       rd_pipe_v;
  logic [ADDR_W-1:0]     rd_pipe_a [T_CL];
  logic [T_CWL-1:0]      wr_pipe_v;
  logic [ADDR_W-1:0]     wr_pipe_a [T_CWL];

  logic [BANK_BITS-1:0]  cur_bank;
  logic [2:0]            err_c;
  logic                  latch_go;
  logic                  act_go;
  logic                  rd_go;
  logic                  wr_go;
  logic                  pre_go;
  logic                  ref_go;
  logic [ADDR_W-1:0]     cmp_addr;

  // Decide what the command on the bus does this cycle (effect or violation)
  always_comb begin
    err_c    = ERR_NONE;
    latch_go = 1'b0;
    act_go   = 1'b0;
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    pre_go   = 1'b0;
    ref_go   = 1'b0;
    cur_bank = {cmd_bg, cmd_bank};
    cmp_addr = {pend_bank, row_q[pend_bank], pend_col};
    if (state == ST_IDLE) begin
      if (cmd_valid) begin
        if (cmd == CMD_ACT1 || cmd == CMD_RD1 || cmd == CMD_WR1) begin
          err_c = ERR_SEQ;
        end else if (busy) begin
          err_c = ERR_BUSY;
        end else if (cmd == CMD_PRE) begin
          // PRE to a closed bank is a silent no-op that keeps its tRP timer
          pre_go = open_mask[cur_bank];
        end else if (cmd == CMD_REF) begin
          if (|open_mask) err_c = ERR_REF_OPEN;
          else            ref_go = 1'b1;
        end else begin
          latch_go = 1'b1;
        end
      end
    end else begin
      if (!cmd_valid || cmd != 3'(pend_cmd + 3'd1)) begin
        err_c = ERR_SEQ;
      end else if (pend_cmd == CMD_ACT0) begin
        if (open_mask[pend_bank])                      err_c = ERR_OPEN;
        else if (tmr_q[pend_bank] < TMR_W'(T_RP))      err_c = ERR_TRP;
        else                                           act_go = 1'b1;
      end else begin
        if (!open_mask[pend_bank])                     err_c = ERR_CLOSED;
        else if (tmr_q[pend_bank] < TMR_W'(T_RCD))     err_c = ERR_TRCD;
        else if (pend_cmd == CMD_RD0)                  rd_go = 1'b1;
        else                                           wr_go = 1'b1;
      end
    end
  end

  // Decode FSM: hold the first half of a two-cycle command
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend_cmd  <= 3'd0;
      pend_bank <= '0;
      pend_row  <= '0;
      pend_col  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (latch_go) begin
            state     <= ST_HALF;
            pend_cmd  <= cmd;
            pend_bank <= cur_bank;
            pend_row  <= cmd_row;
            pend_col  <= cmd_col;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-bank open state, open row and saturating cycles-since-ACT/PRE timer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      open_mask <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b] <= '0;
        tmr_q[b] <= TMR_W'(T_MAX);
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if ((act_go && pend_bank == BANK_BITS'(b)) || (pre_go && cur_bank == BANK_BITS'(b)))
          tmr_q[b] <= TMR_W'(1);
        else if (tmr_q[b] != TMR_W'(T_MAX))
          tmr_q[b] <= tmr_q[b] + TMR_W'(1);
      end
      if (act_go) begin
        open_mask[pend_bank] <= 1'b1;
        row_q[pend_bank]     <= pend_row;
      end
      if (pre_go) open_mask[cur_bank] <= 1'b0;
    end
  end

  // Refresh window: busy for T_RFC cycles after an accepted REF
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      rfc_cnt <= '0;
    end else if (ref_go) begin
      busy    <= 1'b1;
      rfc_cnt <= RFC_W'(T_RFC - 1);
    end else if (busy) begin
      if (rfc_cnt == '0) busy <= 1'b0;
      else               rfc_cnt <= rfc_cnt - RFC_W'(1);
    end
  end

  // Violation report, one pulse per offending cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      err_valid <= (err_c != ERR_NONE);
      err_code  <= err_c;
    end
  end

  // Read completion delay line, one slot per cycle of CL
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pipe_v <= '0;
      for (int i = 0; i < T_CL; i++) rd_pipe_a[i] <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
    end else begin
      rd_pipe_v    <= {rd_pipe_v[T_CL-2:0], rd_go};
      rd_pipe_a[0] <= cmp_addr;
      for (int i = 1; i < T_CL; i++) rd_pipe_a[i] <= rd_pipe_a[i-1];
      rd_valid     <= rd_pipe_v[T_CL-1];
      rd_addr      <= rd_pipe_v[T_CL-1] ? rd_pipe_a[T_CL-1] : '0;
    end
  end

  // Write completion delay line, one slot per cycle of CWL
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_pipe_v <= '0;
      for (int i = 0; i < T_CWL; i++) wr_pipe_a[i] <= '0;
      wr_done   <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_pipe_v    <= {wr_pipe_v[T_CWL-2:0], wr_go};
      wr_pipe_a[0] <= cmp_addr;
      for (int i = 1; i < T_CWL; i++) wr_pipe_a[i] <= wr_pipe_a[i-1];
      wr_done      <= wr_pipe_v[T_CWL-1];
      wr_addr      <= wr_pipe_v[T_CWL-1] ? wr_pipe_a[T_CWL-1] : '0;
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Scoreboard bench for ddr5_cmd_responder. Cycle N is the rising edge that
// samples a command; outputs registered at edge N are observed on the
// following falling edge.
module tb_ddr5_cmd_responder;

  localparam int T_CL  = 40;
  localparam int T_CWL = 38;

  localparam logic [2:0] ACT0 = 3'd0, ACT1 = 3'd1, RD0 = 3'd2, RD1 = 3'd3,
                         WR0 = 3'd4, WR1 = 3'd5, PRE = 3'd6, REFC = 3'd7;

  typedef struct {
    int          cyc;
    logic [2:0]  code;
    logic [30:0] addr;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [2:0]  cmd_bg = 3'd0;
  logic [1:0]  cmd_bank = 2'd0;
  logic [15:0] cmd_row = 16'd0;
  logic [9:0]  cmd_col = 10'd0;
  logic        rd_valid, wr_done, err_valid, busy;
  logic [30:0] rd_addr, wr_addr;
  logic [2:0]  err_code;
  logic [31:0] open_mask;

  int cyc = 0;
  int base = 0;
  int n_chk = 0;
  int n_bad = 0;

  ev_t errq[$];
  ev_t rdq[$];
  ev_t wrq[$];

  ddr5_cmd_responder dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .wr_done(wr_done), .wr_addr(wr_addr),
    .err_valid(err_valid), .err_code(err_code), .busy(busy), .open_mask(open_mask)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [30:0] mk_addr(input logic [2:0] bg, input logic [1:0] ba,
                                          input logic [15:0] row, input logic [9:0] col);
    return {bg, ba, row, col};
  endfunction

  // Compare DUT pulses against the scoreboard every cycle
  always @(negedge clock) begin : mon
    logic [3:0]  exp_e;
    logic        exp_r, exp_w;
    logic [30:0] ea_r, ea_w;
    ev_t         ev;
    exp_e = 4'd0; exp_r = 1'b0; exp_w = 1'b0; ea_r = '0; ea_w = '0;
    if (errq.size() != 0 && errq[0].cyc == cyc) begin
      exp_e = {1'b1, errq[0].code};
      ev = errq.pop_front();
    end
    check_eq("err", 64'({err_valid, err_code}), 64'(exp_e));
    if (rdq.size() != 0 && rdq[0].cyc == cyc) begin
      exp_r = 1'b1; ea_r = rdq[0].addr;
      ev = rdq.pop_front();
    end
    if (rd_valid || exp_r) check_eq("rd", 64'({rd_valid, rd_addr}), 64'({exp_r, ea_r}));
    if (wrq.size() != 0 && wrq[0].cyc == cyc) begin
      exp_w = 1'b1; ea_w = wrq[0].addr;
      ev = wrq.pop_front();
    end
    if (wr_done || exp_w) check_eq("wr", 64'({wr_done, wr_addr}), 64'({exp_w, ea_w}));
  end

  task automatic at(input int r);
    while (cyc < base + r) @(negedge clock);
  endtask

  task automatic send(input int r, input logic [2:0] c, input logic [2:0] bg,
                      input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col);
    int n;
    n = base + r;
    if (cyc >= n) begin
      check_eq("sched_late", 64'(cyc), 64'(n - 1));
    end else begin
      while (cyc != n - 1) @(negedge clock);
      cmd_valid = 1'b1; cmd = c; cmd_bg = bg; cmd_bank = ba; cmd_row = row; cmd_col = col;
      @(negedge clock);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic act(input int r, input logic [2:0] bg, input logic [1:0] ba, input logic [15:0] row);
    send(r, ACT0, bg, ba, row, 10'd0);
    send(r + 1, ACT1, bg, ba, row, 10'd0);
  endtask

  task automatic rd(input int r, input logic [2:0] bg, input logic [1:0] ba, input logic [9:0] col);
    send(r, RD0, bg, ba, 16'd0, col);
    send(r + 1, RD1, bg, ba, 16'd0, col);
  endtask

  task automatic wr(input int r, input logic [2:0] bg, input logic [1:0] ba, input logic [9:0] col);
    send(r, WR0, bg, ba, 16'd0, col);
    send(r + 1, WR1, bg, ba, 16'd0, col);
  endtask

  task automatic exp_err(input int r, input logic [2:0] code);
    errq.push_back('{base + r, code, 31'd0});
  endtask

  task automatic exp_rd(input int r, input logic [30:0] a);
    rdq.push_back('{base + r, 3'd0, a});
  endtask

  task automatic exp_wr(input int r, input logic [30:0] a);
    wrq.push_back('{base + r, 3'd0, a});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("rst_outs", 64'({rd_valid, wr_done, err_valid, err_code, busy, open_mask}), 64'd0);
    check_eq("rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic check_drained(input string tag);
    check_eq(tag, 64'(errq.size() + rdq.size() + wrq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic ACT/RD with a concurrent WR, then PRE with completions in flight
    do_reset();
    at(9);
    check_eq("open_pre_act", 64'(open_mask), 64'd0);
    act(10, 3'd2, 2'd1, 16'h1234);
    check_eq("open_act", 64'(open_mask), 64'h200);
    exp_rd(51 + T_CL, mk_addr(3'd2, 2'd1, 16'h1234, 10'h020));
    rd(50, 3'd2, 2'd1, 10'h020);
    exp_wr(53 + T_CWL, mk_addr(3'd2, 2'd1, 16'h1234, 10'h033));
    wr(52, 3'd2, 2'd1, 10'h033);
    send(55, PRE, 3'd2, 2'd1, 16'd0, 10'd0);
    check_eq("open_after_pre", 64'(open_mask), 64'd0);
    at(100);
    check_drained("s1_drained");

    // tRCD one cycle short, RD to closed bank, ACT to open bank
    do_reset();
    act(10, 3'd2, 2'd1, 16'h1234);
    exp_err(49, 3'd4);
    rd(48, 3'd2, 2'd1, 10'h020);
    exp_err(61, 3'd3);
    rd(60, 3'd0, 2'd0, 10'h001);
    exp_err(71, 3'd2);
    act(70, 3'd2, 2'd1, 16'h0777);
    at(140);
    check_drained("s2_drained");

    // Broken two-cycle sequences
    do_reset();
    send(5, ACT0, 3'd2, 2'd1, 16'h0055, 10'd0);
    exp_err(6, 3'd1);
    send(6, PRE, 3'd2, 2'd1, 16'd0, 10'd0);
    check_eq("open_seq_err", 64'(open_mask), 64'd0);
    act(7, 3'd2, 2'd1, 16'h0066);
    check_eq("open_fresh_act", 64'(open_mask), 64'h200);
    exp_err(20, 3'd1);
    send(20, RD1, 3'd2, 2'd1, 16'd0, 10'd0);
    exp_err(31, 3'd1);
    send(30, RD0, 3'd2, 2'd1, 16'd0, 10'd0);
    exp_rd(61 + T_CL, mk_addr(3'd2, 2'd1, 16'h0066, 10'h005));
    rd(60, 3'd2, 2'd1, 10'h005);
    at(110);
    check_drained("s3_drained");

    // tRP enforcement; PRE to a closed bank does not restart the timer
    do_reset();
    act(10, 3'd2, 2'd1, 16'h0100);
    send(100, PRE, 3'd2, 2'd1, 16'd0, 10'd0);
    check_eq("open_pre9", 64'(open_mask), 64'd0);
    send(105, PRE, 3'd0, 2'd0, 16'd0, 10'd0);
    send(120, PRE, 3'd2, 2'd1, 16'd0, 10'd0);
    exp_err(131, 3'd5);
    act(130, 3'd2, 2'd1, 16'h0200);
    check_eq("open_trp_err", 64'(open_mask), 64'd0);
    act(138, 3'd2, 2'd1, 16'h0200);
    check_eq("open_trp_ok", 64'(open_mask), 64'h200);
    at(145);
    check_drained("s4_drained");

    // Refresh window and REF with a bank open
    do_reset();
    at(199);
    check_eq("busy_before", 64'(busy), 64'd0);
    send(200, REFC, 3'd0, 2'd0, 16'd0, 10'd0);
    check_eq("busy_start", 64'(busy), 64'd1);
    exp_err(300, 3'd7);
    send(300, ACT0, 3'd2, 2'd1, 16'h0300, 10'd0);
    at(494);
    check_eq("busy_last", 64'(busy), 64'd1);
    at(495);
    check_eq("busy_end", 64'(busy), 64'd0);
    act(496, 3'd2, 2'd1, 16'h0300);
    check_eq("open_after_rfc", 64'(open_mask), 64'h200);
    exp_err(510, 3'd6);
    send(510, REFC, 3'd0, 2'd0, 16'd0, 10'd0);
    check_eq("busy_ref_rej", 64'(busy), 64'd0);
    at(520);
    check_drained("s5_drained");

    // Back-to-back reads complete independently
    do_reset();
    act(10, 3'd2, 2'd1, 16'hbeef);
    exp_rd(61 + T_CL, mk_addr(3'd2, 2'd1, 16'hbeef, 10'h001));
    rd(60, 3'd2, 2'd1, 10'h001);
    exp_rd(63 + T_CL, mk_addr(3'd2, 2'd1, 16'hbeef, 10'h002));
    rd(62, 3'd2, 2'd1, 10'h002);
    at(110);
    check_drained("s6_drained");

    // Same traffic, reset while completions are in flight
    do_reset();
    act(10, 3'd2, 2'd1, 16'hbeef);
    rd(60, 3'd2, 2'd1, 10'h001);
    rd(62, 3'd2, 2'd1, 10'h002);
    at(79);
    check_eq("open_before_rst", 64'(open_mask), 64'h200);
    do_reset();
    at(60);
    check_eq("open_after_rst", 64'(open_mask), 64'd0);
    check_drained("s7_drained");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
